// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: forwarding, load-use/MDU stall and branch-flush control for a 5-stage pipeline,
// with an MDU occupancy tracker and saturating stall/flush counters.
module hazard_fwd_unit #(
  parameter int AW = 5,
  parameter int NREAD = 2,
  parameter int MDU_LAT = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NREAD*AW-1:0]   id_src_addr,
  input  logic [NREAD-1:0]      id_src_used,
  input  logic [NREAD*AW-1:0]   ex_src_addr,
  input  logic                  ex_wr_en,
  input  logic [AW-1:0]         ex_wr_addr,
  input  logic                  ex_is_load,
  input  logic                  mem_wr_en,
  input  logic [AW-1:0]         mem_wr_addr,
  input  logic                  wb_wr_en,
  input  logic [AW-1:0]         wb_wr_addr,
  input  logic                  id_branch_taken,
  input  logic                  id_mdu_start,
  input  logic                  id_uses_hilo,
  input  logic                  clr_cnt,
  output logic [NREAD*2-1:0]    fwd_sel,
  output logic [NREAD-1:0]      id_fwd_ex,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  mdu_busy,
  output logic                  mdu_done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int MW = $clog2(MDU_LAT + 1);
  logic [MW-1:0] mdu_cnt;
  logic [NREAD-1:0] lu;
  logic load_use, mdu_hz;
  genvar k;
  for (k = 0; k < NREAD; k++) begin : g_src
    logic [AW-1:0] ex_src, id_src;
    logic mem_hit, wb_hit, id_hit;
    assign ex_src = ex_src_addr[k*AW +: AW];
    assign id_src = id_src_addr[k*AW +: AW];
    assign mem_hit = mem_wr_en && mem_wr_addr != '0 && mem_wr_addr == ex_src;
    assign wb_hit = wb_wr_en && wb_wr_addr != '0 && wb_wr_addr == ex_src;
    assign fwd_sel[k*2 +: 2] = mem_hit ? 2'b10 : wb_hit ? 2'b01 : 2'b00;
    assign id_hit = ex_wr_en && ex_wr_addr != '0 && ex_wr_addr == id_src && id_src_used[k];
    assign id_fwd_ex[k] = id_hit && !ex_is_load;
    assign lu[k] = id_hit && ex_is_load;
  end
  assign load_use = |lu;
  assign mdu_busy = mdu_cnt != '0;
  assign mdu_hz = mdu_busy && (id_uses_hilo || id_mdu_start);
  assign stall_if_id = load_use || mdu_hz;
  assign bubble_id_ex = stall_if_id;
  // a stalled branch is not flushed now; it resolves again next cycle
  assign flush_if_id = id_branch_taken && !stall_if_id;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mdu_cnt <= '0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= mdu_cnt == MW'(1);
      mdu_cnt <= (id_mdu_start && !stall_if_id) ? MW'(MDU_LAT) : mdu_busy ? mdu_cnt - MW'(1) : mdu_cnt;
    end
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if_id && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: vector table, hand-written MDU/reset/saturation sequences and a randomized
// run against a cycle-level reference model.
module tb_hazard_fwd_unit;
  localparam int AW = 5, NREAD = 2, MDU_LAT = 8, CNT_W = 4;
  logic clk = 1'b0, nrst = 1'b0;
  logic [9:0] id_src_addr, ex_src_addr;
  logic [1:0] id_src_used;
  logic ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic [4:0] ex_wr_addr, mem_wr_addr, wb_wr_addr;
  logic id_branch_taken, id_mdu_start, id_uses_hilo, clr_cnt;
  logic [3:0] fwd_sel;
  logic [1:0] id_fwd_ex;
  logic stall_if_id, bubble_id_ex, flush_if_id, mdu_busy, mdu_done;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;

  hazard_fwd_unit #(.AW(AW), .NREAD(NREAD), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .ex_src_addr(ex_src_addr), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .id_branch_taken(id_branch_taken), .id_mdu_start(id_mdu_start), .id_uses_hilo(id_uses_hilo),
    .clr_cnt(clr_cnt), .fwd_sel(fwd_sel), .id_fwd_ex(id_fwd_ex), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] id_src; logic [1:0] used; logic [9:0] ex_src;
    logic ex_we; logic [4:0] ex_wa; logic ex_ld;
    logic mem_we; logic [4:0] mem_wa; logic wb_we; logic [4:0] wb_wa; logic br;
    logic [3:0] e_fwd; logic [1:0] e_idf; logic e_st; logic e_fl;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src_addr = '0; ex_src_addr = '0; id_src_used = '0;
    ex_wr_en = 0; ex_is_load = 0; mem_wr_en = 0; wb_wr_en = 0;
    ex_wr_addr = '0; mem_wr_addr = '0; wb_wr_addr = '0;
    id_branch_taken = 0; id_mdu_start = 0; id_uses_hilo = 0; clr_cnt = 0;
  endtask

  // reference model state
  int rem, m_stall, m_flush;
  logic m_done;

  initial begin
    logic [3:0] e_fwd;
    logic [1:0] e_idf;
    logic lu, e_st, e_fl;
    logic [4:0] es, is_a;
    clear_inputs();
    tbl[0] = '{10'd0, 2'b00, {5'd0, 5'd3}, 0, 5'd0, 0, 1, 5'd3, 1, 5'd3, 0, 4'b0010, 2'b00, 0, 0};
    tbl[1] = '{10'd0, 2'b00, {5'd0, 5'd3}, 0, 5'd0, 0, 1, 5'd0, 1, 5'd3, 0, 4'b0001, 2'b00, 0, 0};
    tbl[2] = '{10'd0, 2'b00, {5'd3, 5'd4}, 0, 5'd0, 0, 1, 5'd4, 1, 5'd3, 0, 4'b0110, 2'b00, 0, 0};
    tbl[3] = '{{5'd5, 5'd9}, 2'b11, 10'd0, 1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 4'b0000, 2'b00, 1, 0};
    tbl[4] = '{{5'd5, 5'd9}, 2'b01, 10'd0, 1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 4'b0000, 2'b00, 0, 0};
    tbl[5] = '{{5'd0, 5'd9}, 2'b11, 10'd0, 1, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 4'b0000, 2'b00, 0, 0};
    tbl[6] = '{{5'd2, 5'd7}, 2'b11, 10'd0, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0, 0, 4'b0000, 2'b01, 0, 0};
    tbl[7] = '{{5'd5, 5'd9}, 2'b11, 10'd0, 1, 5'd5, 1, 0, 5'd0, 0, 5'd0, 1, 4'b0000, 2'b00, 1, 0};
    tbl[8] = '{{5'd5, 5'd9}, 2'b11, 10'd0, 0, 5'd5, 1, 0, 5'd0, 0, 5'd0, 1, 4'b0000, 2'b00, 0, 1};
    tbl[9] = '{10'd0, 2'b11, 10'd0, 1, 5'd0, 0, 1, 5'd0, 1, 5'd0, 0, 4'b0000, 2'b00, 0, 0};
    #2;
    chk("reset_busy", mdu_busy, 0);
    chk("reset_done", mdu_done, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    #10 nrst = 1;

    foreach (tbl[i]) begin
      tick();
      id_src_addr = tbl[i].id_src; id_src_used = tbl[i].used; ex_src_addr = tbl[i].ex_src;
      ex_wr_en = tbl[i].ex_we; ex_wr_addr = tbl[i].ex_wa; ex_is_load = tbl[i].ex_ld;
      mem_wr_en = tbl[i].mem_we; mem_wr_addr = tbl[i].mem_wa;
      wb_wr_en = tbl[i].wb_we; wb_wr_addr = tbl[i].wb_wa; id_branch_taken = tbl[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_sel", i), fwd_sel, tbl[i].e_fwd);
      chk($sformatf("vec%0d_id_fwd_ex", i), id_fwd_ex, tbl[i].e_idf);
      chk($sformatf("vec%0d_stall", i), stall_if_id, tbl[i].e_st);
      chk($sformatf("vec%0d_bubble", i), bubble_id_ex, tbl[i].e_st);
      chk($sformatf("vec%0d_flush", i), flush_if_id, tbl[i].e_fl);
    end

    // branch held off by load-use, then flushed once the hazard clears
    tick(); clear_inputs(); clr_cnt = 1;
    tick(); clr_cnt = 0;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5; id_src_addr = {5'd5, 5'd0}; id_src_used = 2'b10;
    id_branch_taken = 1;
    @(negedge clk);
    chk("clr_stall_cnt", stall_cnt, 0);
    chk("clr_flush_cnt", flush_cnt, 0);
    chk("br_lu_stall", stall_if_id, 1);
    chk("br_lu_flush", flush_if_id, 0);
    tick(); ex_wr_en = 0; ex_is_load = 0;
    @(negedge clk);
    chk("br_retry_flush", flush_if_id, 1);
    chk("br_retry_stall", stall_if_id, 0);
    chk("br_stall_cnt", stall_cnt, 1);
    tick(); id_branch_taken = 0;
    @(negedge clk);
    chk("br_flush_cnt", flush_cnt, 1);

    // MDU occupancy, HI/LO stall and done pulse
    tick(); clear_inputs(); id_mdu_start = 1;
    @(negedge clk);
    chk("mdu_c0_busy", mdu_busy, 0);
    chk("mdu_c0_stall", stall_if_id, 0);
    for (int c = 1; c <= 10; c++) begin
      tick(); id_mdu_start = 0; id_uses_hilo = (c >= 4);
      @(negedge clk);
      chk($sformatf("mdu_c%0d_busy", c), mdu_busy, (c <= 8));
      chk($sformatf("mdu_c%0d_stall", c), stall_if_id, (c >= 4 && c <= 8));
      chk($sformatf("mdu_c%0d_done", c), mdu_done, (c == 9));
    end

    // reset in the middle of an MDU operation
    tick(); clear_inputs(); id_mdu_start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick(); id_mdu_start = 0;
    end
    #1 nrst = 0;
    #1;
    chk("rst_mid_busy", mdu_busy, 0);
    chk("rst_mid_done", mdu_done, 0);
    #1 nrst = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_no_done", mdu_done, 0);
    end

    // stall counter saturation and clear-over-increment
    tick(); clr_cnt = 1;
    tick(); clr_cnt = 0;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd5; id_src_addr = {5'd0, 5'd5}; id_src_used = 2'b01;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, 15);
    tick(); clr_cnt = 1;
    @(negedge clk);
    chk("clr_during_stall", stall_if_id, 1);
    tick(); clear_inputs();
    @(negedge clk);
    chk("clr_over_inc", stall_cnt, 0);

    // randomized run against the reference model
    tick(); #1 nrst = 0; #1 nrst = 1;
    rem = 0; m_stall = 0; m_flush = 0; m_done = 0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      id_src_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_src_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_used = 2'($urandom);
      ex_wr_en = 1'($urandom); ex_wr_addr = 5'($urandom_range(0, 3));
      ex_is_load = ($urandom_range(0, 2) == 0);
      mem_wr_en = 1'($urandom); mem_wr_addr = 5'($urandom_range(0, 3));
      wb_wr_en = 1'($urandom); wb_wr_addr = 5'($urandom_range(0, 3));
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_mdu_start = ($urandom_range(0, 7) == 0);
      id_uses_hilo = ($urandom_range(0, 5) == 0);
      clr_cnt = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      lu = 0;
      for (int k = 0; k < 2; k++) begin
        es = ex_src_addr[k*5 +: 5];
        is_a = id_src_addr[k*5 +: 5];
        if (mem_wr_en && mem_wr_addr != 0 && mem_wr_addr == es) e_fwd[k*2 +: 2] = 2'b10;
        else if (wb_wr_en && wb_wr_addr != 0 && wb_wr_addr == es) e_fwd[k*2 +: 2] = 2'b01;
        else e_fwd[k*2 +: 2] = 2'b00;
        e_idf[k] = ex_wr_en && ex_wr_addr != 0 && ex_wr_addr == is_a && id_src_used[k] && !ex_is_load;
        if (ex_wr_en && ex_wr_addr != 0 && ex_wr_addr == is_a && id_src_used[k] && ex_is_load) lu = 1;
      end
      e_st = lu || (rem > 0 && (id_uses_hilo || id_mdu_start));
      e_fl = id_branch_taken && !e_st;
      chk("rnd_fwd_sel", fwd_sel, e_fwd);
      chk("rnd_id_fwd_ex", id_fwd_ex, e_idf);
      chk("rnd_stall", stall_if_id, e_st);
      chk("rnd_bubble", bubble_id_ex, e_st);
      chk("rnd_flush", flush_if_id, e_fl);
      chk("rnd_busy", mdu_busy, rem > 0);
      chk("rnd_done", mdu_done, m_done);
      chk("rnd_stall_cnt", stall_cnt, m_stall);
      chk("rnd_flush_cnt", flush_cnt, m_flush);
      m_done = (rem == 1);
      if (id_mdu_start && !e_st) rem = MDU_LAT;
      else if (rem > 0) rem--;
      if (clr_cnt) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (e_st) m_stall = (m_stall < 15) ? m_stall + 1 : 15;
        if (e_fl) m_flush = (m_flush < 15) ? m_flush + 1 : 15;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage pipeline.
- Generalises the fixed two-source (rs/rt) MEM/WB forwarding and load-use/branch logic to NREAD source ports with an x0 guard.
- Adds a multi-cycle multiply/divide (MDU) busy tracker that stalls dependent issue.
- Adds saturating stall and flush performance counters.
- Sits between the stage modules and the IF/ID and ID/EX pipeline registers.

Parameters:
- AW, 5, register address width
- NREAD, 2, number of source operands per instruction
- MDU_LAT, 8, MDU occupancy in cycles after accepted start (>=1)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- id_src_addr  in  NREAD*AW  ID-stage source addresses; port k at bits [k*AW +: AW]
- id_src_used  in  NREAD  ID source k is actually read
- ex_src_addr  in  NREAD*AW  EX-stage source addresses
- ex_wr_en  in  1  EX instruction writes a register
- ex_wr_addr  in  AW  EX destination
- ex_is_load  in  1  EX instruction is a load
- mem_wr_en  in  1  MEM instruction writes a register
- mem_wr_addr  in  AW  MEM destination
- wb_wr_en  in  1  WB instruction writes a register
- wb_wr_addr  in  AW  WB destination
- id_branch_taken  in  1  ID resolved a taken branch or jump
- id_mdu_start  in  1  ID instruction launches an MDU operation
- id_uses_hilo  in  1  ID instruction reads HI/LO
- clr_cnt  in  1  synchronous performance-counter clear
- fwd_sel  out  NREAD*2  per EX source: 00 regfile/pipe, 10 MEM ALU result, 01 WB data
- id_fwd_ex  out  NREAD  bypass EX ALU result into ID read k
- stall_if_id  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  insert NOP into ID/EX
- flush_if_id  out  1  squash IF/ID
- mdu_busy  out  1  MDU occupied
- mdu_done  out  1  one-cycle pulse when MDU finishes
- stall_cnt  out  CNT_W  cycles with stall_if_id=1
- flush_cnt  out  CNT_W  cycles with flush_if_id=1

Behaviour:
- fwd_sel[k], combinational:
  - 10 if mem_wr_en, mem_wr_addr!=0 and mem_wr_addr==ex_src k.
  - Else 01 if wb_wr_en, wb_wr_addr!=0 and wb_wr_addr==ex_src k.
  - Else 00. MEM beats WB when both match.
- id_fwd_ex[k] = ex_wr_en & ~ex_is_load & ex_wr_addr!=0 & ex_wr_addr==id_src k & id_src_used[k]; combinational.
- load_use = OR over k of (ex_is_load & ex_wr_en & ex_wr_addr!=0 & ex_wr_addr==id_src k & id_src_used[k]).
- mdu_hz = mdu_busy & (id_uses_hilo | id_mdu_start).
- stall_if_id = bubble_id_ex = load_use | mdu_hz.
- flush_if_id = id_branch_taken & ~stall_if_id. Stall wins; the branch re-resolves next cycle.
- MDU counter (width clog2(MDU_LAT+1)), reset 0:
  - Accepted start = id_mdu_start & ~stall_if_id; loads MDU_LAT on the next edge.
  - Otherwise decrements by 1 while nonzero.
  - mdu_busy = (counter != 0), combinational from the counter.
  - A start cannot be accepted while busy, because it stalls.
- mdu_done: registered; 1 in the cycle after the counter transitions 1 -> 0.
- Performance counters, on each edge:
  - clr_cnt=1 sets both to 0; clear has priority over increment.
  - Otherwise stall_cnt increments when stall_if_id=1 and flush_cnt increments when flush_if_id=1.
  - Both saturate at all-ones; no wrap.
- Reset (nrst=0, asynchronous):
  - MDU counter, mdu_done, stall_cnt and flush_cnt go to 0 immediately; mdu_busy=0.
  - Combinational outputs then depend only on the inputs.
  - Reset mid-MDU-operation abandons the operation with no done pulse.
- Latency: all hazard and forwarding outputs act in the same cycle (zero latency); counter effects appear one edge later.

Test Plan:
- EX src0=3, MEM writes r3 and WB writes r3 -> fwd_sel[1:0]=10. MEM writes r0 instead -> 01.
- EX load to r5, ID src1=5 used -> stall_if_id=bubble_id_ex=1 for 1 cycle. Same with id_src_used[1]=0, or load to r0 -> no stall.
- EX non-load writing r7, ID src0=7 -> id_fwd_ex[0]=1, no stall.
- id_branch_taken together with load_use -> flush_if_id=0, stall=1. Next cycle, hazard cleared -> flush_if_id=1, flush_cnt+1.
- MDU_LAT=8: accepted start at cycle 0 -> mdu_busy cycles 1..8, mdu_done at cycle 9. id_uses_hilo at cycle 4 -> stall until busy drops. nrst pulse at cycle 5 -> busy=0 immediately, no done pulse.
- CNT_W=4, 20 stall cycles -> stall_cnt holds 15. clr_cnt concurrent with stall -> 0.
